pwm_multi_channel_gen: RTL and testbench

// - Parametrised N-channel PWM generator with push-button duty control; next generation of the single-channel button PWM.
// - One shared period counter drives CHANNELS outputs. Each channel has its own duty register.
// - Debounced increase/decrease buttons step the duty of the channel chosen by ch_sel.
// - Duty updates take effect only at a period boundary (glitch-free). Edge-aligned and centre-aligned modes are supported.
// - Sits between board buttons/switches and motor/LED drivers.

---
 rtl/pwm_multi_channel_gen_pkg.sv | 28 ++
 rtl/pwm_btn_debounce.sv | 62 ++++++
 rtl/pwm_multi_channel_gen.sv | 189 ++++++++++++++++++
 tb/tb_pwm_multi_channel_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_channel_gen_pkg.sv
// Shared constants, direction encoding and width helpers for the multi-channel PWM generator.
package pwm_multi_channel_gen_pkg;

  localparam int unsigned PWM_MODE_EDGE   = 0;
  localparam int unsigned PWM_MODE_CENTER = 1;

  // Direction of the shared period counter.
  typedef enum logic [0:0] {
    StUp,
    StDown
  } pwm_dir_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned pwm_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

  // Channel-select width; never narrower than one bit.
  function automatic int unsigned pwm_sel_width(input int unsigned channels);
    return (channels > 1) ? pwm_clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample counter, one-cycle press pulse on the
// rising edge of the debounced level.
module pwm_btn_debounce
  import pwm_multi_channel_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = pwm_clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Count consecutive samples disagreeing with the accepted level; flip on the last one.
  always_comb begin
    level_d      = level_q;
    stable_cnt_d = '0;
    press_d      = 1'b0;
    if (sync_q[1] != level_q) begin
      if (stable_cnt_q == CntLast) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        stable_cnt_d = stable_cnt_q + CntOne;
      end
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= 1'b0;
      stable_cnt_q <= '0;
      press_q      <= 1'b0;
    end else begin
      level_q      <= level_d;
      stable_cnt_q <= stable_cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// N-channel PWM generator: shared period counter (edge or centre aligned), per-channel
// shadow/active duty registers stepped by debounced buttons, registered compare outputs.
module pwm_multi_channel_gen
  import pwm_multi_channel_gen_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned PERIOD          = 10,
  parameter int unsigned DUTY_STEP       = 1,
  parameter int unsigned INIT_DUTY       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CENTER_ALIGNED  = PWM_MODE_EDGE,
  localparam int unsigned DW = pwm_clog2(PERIOD + 1),
  localparam int unsigned SW = pwm_sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_increase,
  input  logic                btn_decrease,
  input  logic [SW-1:0]       ch_sel,
  output logic [CHANNELS-1:0] PWM_OUT,
  output logic [DW-1:0]       duty_rd,
  output logic                period_start
);

  localparam int unsigned CW  = pwm_clog2(PERIOD);
  localparam int unsigned DWX = DW + 1;
  localparam logic [CW-1:0]  CntMax   = CW'(PERIOD - 1);
  localparam logic [CW-1:0]  CntOne   = CW'(1);
  localparam logic [DWX-1:0] PeriodX  = DWX'(PERIOD);
  localparam logic [DWX-1:0] StepX    = DWX'(DUTY_STEP);
  localparam logic [DW-1:0]  InitDuty = DW'(INIT_DUTY);
  localparam bit             Centre   = (CENTER_ALIGNED == PWM_MODE_CENTER);

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  logic                inc_press, dec_press;
  pwm_dir_e            dir_q, dir_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                boundary;
  logic [DW-1:0]       shadow_q [CHANNELS];
  logic [DW-1:0]       shadow_d [CHANNELS];
  logic [DW-1:0]       active_q [CHANNELS];
  logic [DW-1:0]       active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q;

  // Saturating duty step in DW+1 bits so the increment cannot wrap.
  function automatic logic [DW-1:0] step_duty(input logic [DW-1:0] duty, input logic up);
    logic [DWX-1:0] wide;
    wide = {1'b0, duty};
    if (up) begin
      wide = wide + StepX;
      if (wide > PeriodX) begin
        wide = PeriodX;
      end
    end else begin
      wide = (wide < StepX) ? '0 : wide - StepX;
    end
    return wide[DW-1:0];
  endfunction

  // Reset asserts asynchronously and releases synchronously to the rest of the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  pwm_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .btn_raw(btn_increase),
    .press  (inc_press)
  );

  pwm_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .btn_raw(btn_decrease),
    .press  (dec_press)
  );

  // Counter/direction state register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      dir_q <= StUp;
      cnt_q <= '0;
    end else begin
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end

  // Next count: sawtooth in edge mode, triangle turning at PERIOD-1 and 0 in centre mode.
  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (!Centre) begin
      dir_d = StUp;
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntOne;
    end else begin
      unique case (dir_q)
        StUp: begin
          if (cnt_q == CntMax) begin
            cnt_d = cnt_q - CntOne;
            // With PERIOD=2 the turn lands straight back on 0, which always counts up.
            dir_d = (cnt_q == CntOne) ? StUp : StDown;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StDown: begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            dir_d = StUp;
          end
        end
        default: begin
          dir_d = StUp;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Period boundary: counter at 0 heading up.
  always_comb begin
    boundary = (cnt_q == '0) && (dir_q == StUp);
  end

  // Shadow update for the selected channel; out-of-range selects match no channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if ((ch_sel == SW'(i)) && (inc_press ^ dec_press)) begin
        shadow_d[i] = step_duty(shadow_q[i], inc_press);
      end
    end
  end

  // Active duties follow the shadows only at a boundary; the compare uses the new value there.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_d[i] = boundary ? shadow_q[i] : active_q[i];
      pwm_d[i]    = (DW'(cnt_q) < active_d[i]);
    end
  end

  // Duty registers, registered outputs and period pulse.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= InitDuty;
        active_q[i] <= InitDuty;
      end
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
    end
  end

  // Read-back of the selected channel's active duty.
  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SW'(i)) begin
        duty_rd = active_q[i];
      end
    end
  end

  assign PWM_OUT      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Bench for pwm_multi_channel_gen: an edge-aligned 4-channel instance and a centre-aligned
// 3-channel instance share the buttons and ch_sel; a period/phase model predicts every output.
module tb_pwm_multi_channel_gen;

  localparam int P   = 10;
  localparam int DEB = 4;
  localparam int STEP = 1;

  logic       clk;
  logic       rst_n, rst_c_n;
  logic       btn_increase, btn_decrease;
  logic [1:0] ch_sel;
  logic [3:0] pwm_e, duty_e, duty_c;
  logic [2:0] pwm_c;
  logic       ps_e, ps_c;

  int n_cmp = 0;
  int n_err = 0;

  pwm_multi_channel_gen u_dut_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_increase(btn_increase),
    .btn_decrease(btn_decrease),
    .ch_sel      (ch_sel),
    .PWM_OUT     (pwm_e),
    .duty_rd     (duty_e),
    .period_start(ps_e)
  );

  pwm_multi_channel_gen #(
    .CHANNELS      (3),
    .INIT_DUTY     (3),
    .CENTER_ALIGNED(1)
  ) u_dut_ctr (
    .clk         (clk),
    .rst_n       (rst_c_n),
    .btn_increase(btn_increase),
    .btn_decrease(btn_decrease),
    .ch_sel      (ch_sel),
    .PWM_OUT     (pwm_c),
    .duty_rd     (duty_c),
    .period_start(ps_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = edge DUT, 1 = centre DUT) ----------------
  int chans_m  [2] = '{4, 3};
  int centre_m [2] = '{0, 1};
  int init_m   [2] = '{5, 3};
  int alive_m  [2];
  bit lvl_m    [2][2];
  bit hist_m   [2][2][8];
  bit pend_m   [2][2];
  int shadow_m [2][4];
  int active_m [2][4];
  bit exp_pwm_m[2][4];
  bit exp_ps_m [2];

  task automatic model_reset(input int d);
    alive_m[d]  = 0;
    exp_ps_m[d] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      lvl_m[d][b]  = 1'b0;
      pend_m[d][b] = 1'b0;
      for (int j = 0; j < 8; j++) hist_m[d][b][j] = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      shadow_m[d][c]  = init_m[d];
      active_m[d][c]  = init_m[d];
      exp_pwm_m[d][c] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int p, len, pos, sel;
    bit raw [2];
    bit all_hi, all_lo;
    raw[0] = btn_increase;
    raw[1] = btn_decrease;
    sel = int'(ch_sel);
    alive_m[d]++;
    len = (centre_m[d] != 0) ? 2 * (P - 1) : P;
    // Outputs of a period appear from the third clock after reset release onward.
    if (alive_m[d] >= 3) begin
      p   = (alive_m[d] - 3) % len;
      pos = (centre_m[d] != 0 && p >= P) ? len - p : p;
      for (int c = 0; c < chans_m[d]; c++) begin
        if (p == 0) active_m[d][c] = shadow_m[d][c];
        exp_pwm_m[d][c] = (pos < active_m[d][c]);
      end
      exp_ps_m[d] = (p == 0);
    end
    // A press accepted last cycle lands now on the channel selected during that cycle.
    if (pend_m[d][0] != pend_m[d][1] && sel < chans_m[d]) begin
      if (pend_m[d][0]) begin
        shadow_m[d][sel] = (shadow_m[d][sel] + STEP > P) ? P : shadow_m[d][sel] + STEP;
      end else begin
        shadow_m[d][sel] = (shadow_m[d][sel] < STEP) ? 0 : shadow_m[d][sel] - STEP;
      end
    end
    // Debounced level flips after DEB equal samples taken two cycles late.
    for (int b = 0; b < 2; b++) begin
      for (int j = 7; j > 0; j--) hist_m[d][b][j] = hist_m[d][b][j-1];
      hist_m[d][b][0] = raw[b];
      all_hi = 1'b1;
      all_lo = 1'b1;
      for (int j = 2; j < DEB + 2; j++) begin
        all_hi = all_hi & hist_m[d][b][j];
        all_lo = all_lo & !hist_m[d][b][j];
      end
      pend_m[d][b] = 1'b0;
      if (!lvl_m[d][b] && all_hi) begin
        lvl_m[d][b]  = 1'b1;
        pend_m[d][b] = 1'b1;
      end else if (lvl_m[d][b] && all_lo) begin
        lvl_m[d][b] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(0);
    else        model_step(0);
  end

  always @(posedge clk or negedge rst_c_n) begin
    if (!rst_c_n) model_reset(1);
    else          model_step(1);
  end

  task automatic compare_dut(input int d, input logic [3:0] pwm, input logic ps,
                             input logic [3:0] duty);
    logic [3:0] exp_vec;
    int exp_duty;
    for (int c = 0; c < 4; c++) exp_vec[c] = exp_pwm_m[d][c];
    exp_duty = (int'(ch_sel) < chans_m[d]) ? active_m[d][int'(ch_sel)] : 0;
    check((d == 0) ? "edge PWM_OUT" : "centre PWM_OUT", 32'(pwm), 32'(exp_vec));
    check((d == 0) ? "edge period_start" : "centre period_start", 32'(ps), 32'(exp_ps_m[d]));
    check((d == 0) ? "edge duty_rd" : "centre duty_rd", 32'(duty), exp_duty);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    compare_dut(0, pwm_e, ps_e, duty_e);
    compare_dut(1, {1'b0, pwm_c}, ps_c, duty_c);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ps(input int d);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (d == 0) ? ps_e : ps_c;
    end
    check("period_start wait", 32'(found), 32'd1);
  endtask

  task automatic count_high(input int d, input int ch, input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      hits += (d == 0) ? int'(pwm_e[ch]) : int'(pwm_c[ch]);
    end
  endtask

  task automatic push(input bit inc, input bit dec, input logic [1:0] ch);
    cyc();
    ch_sel       = ch;
    btn_increase = inc;
    btn_decrease = dec;
    repeat (10) cyc();
    btn_increase = 1'b0;
    btn_decrease = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic check_duty(input string name, input int d, input logic [1:0] ch, input int exp);
    cyc();
    ch_sel = ch;
    @(negedge clk);
    check(name, (d == 0) ? 32'(duty_e) : 32'(duty_c), exp);
  endtask

  int hits;
  int exp_steps [6] = '{6, 7, 8, 7, 6, 5};

  initial begin
    rst_n = 1'b1; rst_c_n = 1'b1;
    btn_increase = 1'b0; btn_decrease = 1'b0; ch_sel = 2'd0;
    #1;
    rst_n = 1'b0; rst_c_n = 1'b0;
    #49;
    @(negedge clk);
    check("reset PWM_OUT", 32'(pwm_e), 32'd0);
    check("reset period_start", 32'(ps_e), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; rst_c_n = 1'b1;

    // Default duty 5 of 10 on every edge channel; period_start every 10 cycles.
    wait_ps(0);
    count_high(0, 0, 10, hits);
    check("reset ch0 high count", hits, 5);
    @(negedge clk);
    check("period_start spacing", 32'(ps_e), 32'd1);
    count_high(0, 3, 10, hits);
    check("reset ch3 high count", hits, 5);
    check_duty("reset duty_rd", 0, 2'd0, 5);

    // Centre mode, duty 3: five consecutive high cycles of 18, centred on cnt 0.
    wait_ps(1);
    check("centre high at cnt0", 32'(pwm_c[0]), 32'd1);
    count_high(1, 0, 18, hits);
    check("centre high count", hits, 5);

    // Three increases then three decreases on channel 0.
    for (int i = 0; i < 6; i++) begin
      push(i < 3, i >= 3, 2'd0);
      repeat (20) cyc();
      check_duty($sformatf("ch0 step %0d", i), 0, 2'd0, exp_steps[i]);
    end
    for (int c = 1; c < 4; c++) check_duty($sformatf("ch%0d untouched", c), 0, 2'(c), 5);

    // Saturation at both ends on channel 2.
    repeat (7) push(1'b1, 1'b0, 2'd2);
    repeat (20) cyc();
    check_duty("ch2 saturate high", 0, 2'd2, 10);
    count_high(0, 2, 10, hits);
    check("ch2 constant high", hits, 10);
    repeat (12) push(1'b0, 1'b1, 2'd2);
    repeat (20) cyc();
    check_duty("ch2 saturate low", 0, 2'd2, 0);
    count_high(0, 2, 10, hits);
    check("ch2 constant low", hits, 0);

    // Bouncing push yields one step; a 3-cycle glitch yields none.
    cyc();
    ch_sel = 2'd0;
    for (int i = 0; i < 10; i++) begin
      btn_increase = ~btn_increase;
      repeat (2) cyc();
    end
    btn_increase = 1'b1;
    repeat (10) cyc();
    btn_increase = 1'b0;
    repeat (10) cyc();
    btn_increase = 1'b1;
    repeat (3) cyc();
    btn_increase = 1'b0;
    repeat (30) cyc();
    check_duty("bounce one step", 0, 2'd0, 6);

    // Simultaneous increase and decrease leave channel 1 alone.
    push(1'b1, 1'b1, 2'd1);
    repeat (20) cyc();
    check_duty("inc+dec no change", 0, 2'd1, 5);

    // ch_sel 3 is valid on the 4-channel unit but out of range on the 3-channel unit.
    push(1'b1, 1'b0, 2'd3);
    repeat (20) cyc();
    check_duty("edge ch3 step", 0, 2'd3, 6);
    check_duty("centre out-of-range read", 1, 2'd3, 0);
    check_duty("centre ch0 duty", 1, 2'd0, 4);
    check_duty("centre ch1 duty", 1, 2'd1, 3);
    check_duty("centre ch2 duty", 1, 2'd2, 0);

    // Reset asserted mid-pulse clears the centre outputs at once and restores INIT_DUTY.
    cyc();
    ch_sel = 2'd0;
    wait_ps(1);
    check("centre pulse before reset", 32'(pwm_c[0]), 32'd1);
    @(posedge clk); #2;
    rst_c_n = 1'b0;
    #1;
    check("centre PWM_OUT in reset", 32'(pwm_c), 32'd0);
    repeat (5) cyc();
    rst_c_n = 1'b1;
    repeat (25) cyc();
    check_duty("centre duty after reset", 1, 2'd0, 3);

    repeat (5) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
